// File: rtl/shuffle_pkg.sv
// shuffle_pkg: shared types, constants and the permutation check for shuffle_ctrl.
package shuffle_pkg;

    typedef enum logic [2:0] {IDLE, INIT, DRAW, SWAP, CHECK, DONE} state_t;

    localparam logic [15:0] LFSR_MASK = 16'hB400;
    localparam int N_ENTRIES = 8;
    localparam int IDX_W = 3;
    localparam int VAL_W = 4;

    // True when no entry has its top bit set and every index 0..7 appears once.
    function automatic logic perm_valid(input logic [N_ENTRIES*VAL_W-1:0] r);
        logic [N_ENTRIES-1:0] seen;
        logic bad;
        seen = '0;
        bad = 1'b0;
        for (int k = 0; k < N_ENTRIES; k++) begin
            bad |= r[VAL_W*k+IDX_W];
            seen |= N_ENTRIES'(1) << r[VAL_W*k +: IDX_W];
        end
        return !bad && (&seen);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1), shifting right, with load.
module lfsr16 import shuffle_pkg::*; #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter int QW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          load,
    input  logic [15:0]   load_val,
    output logic [QW-1:0] q
);
    logic [15:0] s;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) s <= SEED;
        else if (load) s <= load_val;
        else if (en) s <= (s >> 1) ^ (s[0] ? LFSR_MASK : 16'h0);

    assign q = s[QW-1:0];
endmodule

// File: rtl/shuffle_ctrl.sv
// shuffle_ctrl: drives a Fisher-Yates shuffle of the 8-entry permutation file
// using LFSR rejection sampling, then verifies the result is still a permutation.
module shuffle_ctrl import shuffle_pkg::*; #(
    parameter logic [15:0] SEED = 16'hACE1,
    parameter int MAX_RETRY = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             seed_load,
    input  logic [15:0]      seed_in,
    input  logic [31:0]      r_in,
    output logic             init,
    output logic             swapxy,
    output logic [IDX_W-1:0] x,
    output logic [IDX_W-1:0] y,
    output logic             busy,
    output logic             done,
    output logic             perm_ok
);
    state_t state, state_n;
    logic [IDX_W-1:0] i, cand;
    logic [3:0] retry;
    logic accept, give_up;

    lfsr16 #(.SEED(SEED), .QW(IDX_W)) u_lfsr (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state == DRAW),
        .load     (state == IDLE && seed_load),
        .load_val (seed_in == 16'h0 ? SEED : seed_in),
        .q        (cand)
    );

    assign accept  = cand <= i;
    assign give_up = retry == 4'(MAX_RETRY - 1);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? INIT : IDLE;
            INIT:    state_n = DRAW;
            DRAW:    state_n = (accept || give_up) ? SWAP : DRAW;
            SWAP:    state_n = (i == 3'd1) ? CHECK : DRAW;
            CHECK:   state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign init   = state == INIT;
    assign swapxy = state == SWAP;
    assign busy   = state != IDLE;
    assign done   = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            i       <= '0;
            retry   <= '0;
            x       <= '0;
            y       <= '0;
            perm_ok <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && start) perm_ok <= 1'b0;
            if (state == INIT) begin
                i     <= 3'd7;
                retry <= '0;
            end
            // An exhausted retry budget falls back to a harmless self-swap.
            if (state == DRAW) begin
                if (accept || give_up) begin
                    x     <= i;
                    y     <= accept ? cand : i;
                    retry <= '0;
                end else begin
                    retry <= retry + 4'd1;
                end
            end
            if (state == SWAP && i != 3'd1) i <= i - 3'd1;
            if (state == CHECK) perm_ok <= perm_valid(r_in);
        end
    end
endmodule
